// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: per-FU result holding slots, round-robin
// onto one register-file write port with registered outputs.
module fu_wb_arbiter #(
  parameter int N_FU = 4,
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_FU-1:0]      fu_finish,
  input  logic [N_FU*XLEN-1:0] fu_res,
  input  logic [N_FU*RW-1:0]   fu_rd,
  output logic [N_FU-1:0]      fu_busy,
  input  logic                 wb_ready,
  output logic                 wb_we,
  output logic [RW-1:0]        wb_addr,
  output logic [XLEN-1:0]      wb_data,
  output logic [N_FU-1:0]      wb_fu,
  output logic                 err
);

  localparam int PW = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [N_FU-1:0] slot_v;
  logic [XLEN-1:0] slot_res [N_FU];
  logic [RW-1:0]   slot_rd  [N_FU];
  logic [PW-1:0]   ptr;

  logic            gnt;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   cand;
  logic [N_FU-1:0] take;

  assign fu_busy = slot_v;

  // Pick the first valid slot after ptr; scanning farthest-first
  // lets the nearest candidate overwrite, so no early exit needed.
  always_comb begin
    gnt  = 1'b0;
    gidx = ptr;
    cand = ptr;
    if (wb_ready) begin
      for (int k = N_FU; k >= 1; k--) begin
        cand = PW'((int'(ptr) + k) % N_FU);
        if (slot_v[cand]) begin
          gnt  = 1'b1;
          gidx = cand;
        end
      end
    end
    take = gnt ? (N_FU'(1) << gidx) : '0;
  end

  // Slot capture/release, round-robin pointer and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v <= '0;
      ptr    <= PW'(N_FU - 1);
      err    <= 1'b0;
    end else begin
      if (gnt) ptr <= gidx;
      for (int i = 0; i < N_FU; i++) begin
        if (fu_finish[i] && (!slot_v[i] || take[i])) begin
          slot_v[i]   <= 1'b1;
          slot_res[i] <= fu_res[i*XLEN +: XLEN];
          slot_rd[i]  <= fu_rd[i*RW +: RW];
        end else if (take[i]) begin
          slot_v[i] <= 1'b0;
        end
        if (fu_finish[i] && slot_v[i] && !take[i]) err <= 1'b1;
      end
    end
  end

  // Registered write port; addr/data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      wb_fu   <= '0;
    end else begin
      wb_fu <= take;
      wb_we <= gnt && (slot_rd[gidx] != '0);
      if (gnt) begin
        wb_addr <= slot_rd[gidx];
        wb_data <= slot_res[gidx];
      end
    end
  end

endmodule

// File: doc/fu_wb_arbiter.md
Name: fu_wb_arbiter

Overview:
- Writeback stage directly downstream of the scoreboard functional units (ALU, MEM, MUL, DIV).
- Captures each FU's single-cycle `finish` result into a per-FU holding slot.
- Round-robin arbitrates the slots onto the single register-file write port.
- Reports slot occupancy so the scoreboard does not issue to an FU whose previous result has not yet been written back.

Parameters:
- N_FU, 4, number of functional units served (2..8).
- XLEN, 32, result data width.
- RW, 5, register address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- fu_finish  in  N_FU  per-FU one-cycle result-valid pulse.
- fu_res  in  N_FU*XLEN  per-FU result; FU i occupies bits [i*XLEN +: XLEN].
- fu_rd  in  N_FU*RW  per-FU destination register; FU i occupies bits [i*RW +: RW].
- fu_busy  out  N_FU  slot i occupied (result captured, not yet written back).
- wb_ready  in  1  regfile write port available this cycle.
- wb_we  out  1  register-file write enable (registered).
- wb_addr  out  RW  register-file write address (registered).
- wb_data  out  XLEN  register-file write data (registered).
- wb_fu  out  N_FU  one-hot FU released this cycle; scoreboard clears that FU's status (registered).
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset:
  - all slot valid bits = 0, fu_busy = 0, wb_we = 0, wb_addr = 0, wb_data = 0, wb_fu = 0, err = 0.
  - RR pointer = N_FU-1, so FU0 has top priority first.
  - Reset mid-operation discards all held results; no writeback for them.
- Capture:
  - fu_finish[i] = 1 and slot i empty (or being granted this same cycle) → slot i loads fu_res/fu_rd; valid = 1 next cycle.
  - fu_busy[i] = slot i valid (registered state, no combinational path from fu_finish).
- Overflow:
  - fu_finish[i] = 1 while slot i is valid and not granted this cycle → new result dropped, held slot unchanged, err set.
  - err stays set until rst.
- Arbitration, evaluated each cycle when wb_ready = 1 and any slot is valid:
  - Grant the first valid slot searching from (ptr+1) mod N_FU upward with wrap-around.
  - ptr ← granted index.
  - Granted slot valid ← 0 at the same edge, unless refilled by a simultaneous fu_finish.
- Output timing:
  - Outputs are registered; one grant per cycle maximum.
  - On the edge after a grant: wb_fu = onehot(granted), wb_addr/wb_data = slot contents, wb_we = 1 iff slot rd ≠ 0.
  - rd = 0 results are retired (wb_fu pulses) with wb_we = 0.
  - No grant in a cycle → next cycle wb_we = 0, wb_fu = 0; wb_addr/wb_data hold their last values.
- Backpressure:
  - wb_ready = 0 → no grant, ptr unchanged, slots held, captures still accepted into empty slots.
- Latency: fu_finish at edge t → slot valid after t → granted in cycle t+1 if uncontested → wb_we/wb_fu visible after edge t+2. Minimum latency 2 cycles.
- Throughput: one writeback per cycle. With all N_FU slots full, every slot is serviced within N_FU cycles of wb_ready being high (starvation-free).
- Simultaneous events:
  - Grant and refill of the same slot in one cycle are both honoured; the old data is written back and the new data is held.
  - Multiple finishes in one cycle are all captured.

Test Plan:
- Single result: rst, then FU1 finish with res = 0xDEADBEEF, rd = 7 → two cycles later wb_we = 1, wb_addr = 7, wb_data = 0xDEADBEEF, wb_fu = 0010; fu_busy[1] high for exactly 1 cycle.
- Contention: FU0..FU3 finish in the same cycle with res = 0x10..0x13, rd = 1..4 → four consecutive writebacks in order FU0, FU1, FU2, FU3.
  - A second burst of all four then starts at FU0 again, because ptr = 3 after the first burst.
- rd = 0: FU2 finishes with res = 0x55, rd = 0 → wb_fu = 0100 with wb_we = 0; slot cleared.
- Backpressure: hold wb_ready = 0 for 5 cycles with FU0 and FU3 pending → no wb_we, fu_busy = 1001 steady.
  - Release wb_ready → FU0 is written back, then FU3.
- Overflow: FU1 finishes with res = 0xA, then finishes again with res = 0xB while wb_ready = 0 → err = 1 and stays set; the later writeback carries 0xA.
- Refill plus reset: FU0 is granted in the same cycle FU0 finishes with a new res = 0x99 → 0x99 is written back on the following grant.
  - Then assert rst with slots full → all outputs 0 and no further writebacks.
